// File: rtl/i2c_read_master.sv
// rtl/i2c_read_master.sv - single-byte I2C read master with open-drain SCL/SDA
//
// Purpose:
//   Runs one complete I2C read of a single byte for each accepted start:
//   START, address byte with R bit, slave ACK check, eight data bits
//   MSB first, master NACK, STOP. Every bit slot is four quarters of QDIV
//   system clocks. Q0/Q1 hold SCL low, and SDA changes at the start of Q0.
//   Q2/Q3 release SCL. SDA is sampled at the tick that ends Q2.
//
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   start       request one read transaction (ignored while busy)
//   addr_sel    0 selects ADDR_DEFAULT, 1 selects slave_addr
//   slave_addr  alternate 7-bit target address
//   busy        transaction in progress
//   done        one-cycle pulse at transaction end
//   ack_err     address byte was NACKed on the last transaction
//   rx_data     last successfully read byte
//   scl, sda    open-drain bus lines, only ever driven 0 or released
//
// Configuration:
//   I2C_CLK_STRETCH_EN  when defined, the quarter counter holds at the start
//                       of Q2 until synchronised SCL reads high, so a slave
//                       can stretch the clock indefinitely.

module i2c_read_master #(
  parameter int         QDIV         = 250,
  parameter logic [6:0] ADDR_DEFAULT = 7'h57
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       addr_sel,
  input  logic [6:0] slave_addr,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rx_data,
  inout  wire        scl,
  inout  wire        sda
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_ADDR     = 3'd2;
  localparam logic [2:0] S_ADDR_ACK = 3'd3;
  localparam logic [2:0] S_DATA     = 3'd4;
  localparam logic [2:0] S_MNACK    = 3'd5;
  localparam logic [2:0] S_STOP     = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  localparam logic [15:0] QMAX = 16'(QDIV - 1);

  logic [2:0]  state;
  logic [15:0] qcnt;
  logic [1:0]  q;
  logic [2:0]  bitcnt;
  logic [6:0]  addr_lat;
  logic [7:0]  rx_shift;
  logic        nack;
  logic        sda_s1;
  logic        sda_s2;

  logic        tick;
  logic        slot_end;
  logic        sample;
  logic        hold;
  logic        scl_low;
  logic        sda_low;
  logic [7:0]  tx_byte;

  assign tick     = (qcnt == QMAX);
  assign slot_end = tick && (q == 2'd3);
  assign sample   = tick && (q == 2'd2);
  assign tx_byte  = {addr_lat, 1'b1};

  // SDA is asynchronous to clk whenever the slave drives it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
    end else begin
      sda_s1 <= sda;
      sda_s2 <= sda_s1;
    end
  end

`ifdef I2C_CLK_STRETCH_EN
  logic scl_s1;
  logic scl_s2;

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
    end else begin
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
    end
  end

  // Only the first cycle of Q2 waits. The synchroniser still shows the low
  // level of Q1 there, so every released slot costs two extra cycles even
  // without stretching.
  assign hold = (q == 2'd2) && (qcnt == 16'd0) && !scl_s2;
`else
  assign hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      q        <= '0;
      bitcnt   <= '0;
      addr_lat <= '0;
      rx_shift <= '0;
      nack     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      rx_data  <= 8'h00;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE || state == S_DONE) begin
        // DONE lasts one cycle. busy is already low there, so a new start
        // is accepted in it just as in IDLE.
        state  <= S_IDLE;
        qcnt   <= '0;
        q      <= '0;
        bitcnt <= '0;
        if (start) begin
          state    <= S_START;
          busy     <= 1'b1;
          ack_err  <= 1'b0;
          addr_lat <= addr_sel ? slave_addr : ADDR_DEFAULT;
        end
      end else begin
        if (!hold) begin
          if (tick) begin
            qcnt <= '0;
            q    <= q + 2'd1;
          end else begin
            qcnt <= qcnt + 16'd1;
          end
        end

        if (sample) begin
          if (state == S_ADDR_ACK) nack <= sda_s2;
          if (state == S_DATA) rx_shift <= {rx_shift[6:0], sda_s2};
        end

        if (slot_end) begin
          // bitcnt wraps 7 -> 0 by itself at the end of each 8-slot byte.
          bitcnt <= bitcnt + 3'd1;
          case (state)
            S_START: begin
              state  <= S_ADDR;
              bitcnt <= 3'd0;
            end
            S_ADDR: begin
              if (bitcnt == 3'd7) state <= S_ADDR_ACK;
            end
            S_ADDR_ACK: begin
              bitcnt <= 3'd0;
              if (nack) begin
                ack_err <= 1'b1;
                state   <= S_STOP;
              end else begin
                state <= S_DATA;
              end
            end
            S_DATA: begin
              if (bitcnt == 3'd7) state <= S_MNACK;
            end
            S_MNACK: begin
              rx_data <= rx_shift;
              state   <= S_STOP;
            end
            S_STOP: begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
            default: state <= S_IDLE;
          endcase
        end
      end
    end
  end

  // Line control is decoded from registered state only. The bus never sees
  // a driven high level.
  always_comb begin
    scl_low = 1'b0;
    sda_low = 1'b0;
    case (state)
      S_START: begin
        // Q0/Q1 idle bus. Q2/Q3 SDA falls while SCL stays high.
        sda_low = q[1];
      end
      S_ADDR: begin
        scl_low = !q[1];
        sda_low = !tx_byte[3'd7 - bitcnt];
      end
      S_ADDR_ACK, S_DATA, S_MNACK: begin
        scl_low = !q[1];
      end
      S_STOP: begin
        // SDA stays low until SCL has been high for two quarters, then it
        // rises in Q3 to form the STOP condition.
        scl_low = (q == 2'd0);
        sda_low = (q != 2'd3);
      end
      default: begin
        scl_low = 1'b0;
        sda_low = 1'b0;
      end
    endcase
  end

  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

endmodule
